// File: rtl/counter_ramp_ctrl_if.sv
// Target handshake, counter command bus and status flags for counter_ramp_ctrl.
// master = requester/counter side, slave = the controller.
interface counter_ramp_ctrl_if;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_data;
  logic       tgt_jump;
  logic [7:0] cnt_q;
  logic       cnt_preload;
  logic [7:0] cnt_pl_data;
  logic       cnt_up_dn;
  logic [3:0] cnt_delta;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tgt_valid, tgt_data, tgt_jump, cnt_q,
    input  tgt_ready, cnt_preload, cnt_pl_data, cnt_up_dn, cnt_delta, busy, done, err
  );

  modport slave (
    input  tgt_valid, tgt_data, tgt_jump, cnt_q,
    output tgt_ready, cnt_preload, cnt_pl_data, cnt_up_dn, cnt_delta, busy, done, err
  );
endinterface

// File: rtl/counter_ramp_ctrl.sv
// Ramps an external up/down counter to a requested target with bounded steps and stall abort.
// Optional direct-load JUMP state enabled by macro CNT_JUMP_EN.
//
// state | meaning
// IDLE  | waiting for a target, tgt_ready=1
// JUMP  | one-cycle preload of target into counter (CNT_JUMP_EN only)
// RAMP  | stepping toward target, watching for stall
// DONE  | one-cycle done pulse
// ERR   | one-cycle err pulse after stall abort
module counter_ramp_ctrl #(
  parameter int MAX_STEP    = 15,
  parameter int STALL_LIMIT = 8
) (
  input logic                clk,
  input logic                reset,
  counter_ramp_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
`ifdef CNT_JUMP_EN
  localparam logic [2:0] ST_JUMP = 3'd1;
`endif
  localparam logic [2:0] ST_RAMP = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [8:0] MAX_STEP_W    = 9'(MAX_STEP);
  localparam logic [7:0] STALL_LIMIT_W = 8'(STALL_LIMIT);

  logic [2:0] r_state;
  logic [7:0] r_target;
  logic [7:0] r_cnt_q_prev;
  logic [7:0] r_stall_cnt;

  logic [2:0] w_state_nxt;
  logic [7:0] w_stall_nxt;
  logic       w_tgt_gt;
  logic [8:0] w_diff;
  logic [3:0] w_step;
  logic [7:0] w_stall_inc;
  logic       w_no_progress;
  logic       w_accept;

  assign w_accept      = (r_state == ST_IDLE) && bus.tgt_valid;
  assign w_tgt_gt      = r_target > bus.cnt_q;
  assign w_diff        = w_tgt_gt ? ({1'b0, r_target} - {1'b0, bus.cnt_q})
                                  : ({1'b0, bus.cnt_q} - {1'b0, r_target});
  assign w_step        = (w_diff > MAX_STEP_W) ? MAX_STEP_W[3:0] : w_diff[3:0];
  assign w_stall_inc   = r_stall_cnt + 8'd1;
  assign w_no_progress = bus.cnt_q == r_cnt_q_prev;

  always_comb begin
    w_state_nxt = r_state;
    w_stall_nxt = r_stall_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.tgt_valid) begin
          w_stall_nxt = 8'd0;
`ifdef CNT_JUMP_EN
          w_state_nxt = bus.tgt_jump ? ST_JUMP : ST_RAMP;
`else
          w_state_nxt = ST_RAMP;
`endif
        end
      end
`ifdef CNT_JUMP_EN
      ST_JUMP: begin
        w_state_nxt = ST_RAMP;
        w_stall_nxt = 8'd0;
      end
`endif
      ST_RAMP: begin
        if (w_diff == 9'd0) begin
          w_state_nxt = ST_DONE;
          w_stall_nxt = 8'd0;
        end else if (w_no_progress) begin
          w_stall_nxt = w_stall_inc;
          if (w_stall_inc == STALL_LIMIT_W) w_state_nxt = ST_ERR;
        end else begin
          w_stall_nxt = 8'd0;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counter commands follow cnt_q combinationally so the last step never overshoots.
  assign bus.cnt_up_dn = (r_state == ST_RAMP) && w_tgt_gt;
  assign bus.cnt_delta = (r_state == ST_RAMP) ? w_step : 4'd0;
`ifdef CNT_JUMP_EN
  assign bus.cnt_preload = r_state == ST_JUMP;
  assign bus.cnt_pl_data = (r_state == ST_JUMP) ? r_target : 8'd0;
`else
  logic w_unused_jump;
  assign w_unused_jump   = bus.tgt_jump;
  assign bus.cnt_preload = 1'b0;
  assign bus.cnt_pl_data = 8'd0;
`endif

  assign bus.tgt_ready = r_state == ST_IDLE;
  assign bus.busy      = r_state != ST_IDLE;
  assign bus.done      = r_state == ST_DONE;
  assign bus.err       = r_state == ST_ERR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_target     <= 8'd0;
      r_cnt_q_prev <= 8'd0;
      r_stall_cnt  <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt_q_prev <= bus.cnt_q;
      r_stall_cnt  <= w_stall_nxt;
      if (w_accept) r_target <= bus.tgt_data;
    end
  end

endmodule

// File: doc/counter_ramp_ctrl.md
COUNTER_RAMP_CTRL -- requirements
Module: counter_ramp_ctrl

Interface
REQ-001 Parameter MAX_STEP, default 15, largest per-cycle step magnitude; legal range 1..15.
REQ-002 Parameter STALL_LIMIT, default 8, consecutive non-progress RAMP cycles before abort; legal range 2..255.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 tgt_valid  in  1  target request valid.
REQ-006 tgt_ready  out  1  controller can accept a target.
REQ-007 tgt_data  in  8  target counter value.
REQ-008 tgt_jump  in  1  request direct load instead of ramp (used only under CNT_JUMP_EN).
REQ-009 cnt_q  in  8  current value of the driven up/down counter.
REQ-010 cnt_preload  out  1  counter preload command.
REQ-011 cnt_pl_data  out  8  counter preload value.
REQ-012 cnt_up_dn  out  1  counter direction, 1 = up.
REQ-013 cnt_delta  out  4  counter step magnitude.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse, target reached.
REQ-016 err  out  1  one-cycle pulse, ramp aborted on stall.

Function
REQ-017 States: IDLE, JUMP, RAMP, DONE, ERR; state, target register, cnt_q_prev and stall counter are registered.
REQ-018 tgt_ready SHALL be 1 only in IDLE; a transfer occurs on a clock edge with tgt_valid=1 and tgt_ready=1, latching tgt_data into target; tgt_valid outside IDLE is ignored.
REQ-019 On transfer: next state JUMP if tgt_jump=1 and CNT_JUMP_EN defined, else RAMP; stall counter cleared.
REQ-020 cnt_preload, cnt_up_dn, cnt_delta, cnt_pl_data SHALL be combinational from state, target and cnt_q, so each command reflects cnt_q in the same cycle (no overshoot).
REQ-021 In IDLE, DONE, ERR: cnt_preload=0, cnt_delta=0, cnt_up_dn=0 (counter holds).
REQ-022 In RAMP: diff=|target-cnt_q| computed at 9 bits; cnt_up_dn=(target>cnt_q); cnt_delta=min(diff,MAX_STEP); cnt_preload=0.
REQ-023 RAMP with diff=0 SHALL drive cnt_delta=0 and transition to DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-024 cnt_q_prev SHALL sample cnt_q every cycle; in RAMP with diff!=0 the stall counter increments when cnt_q==cnt_q_prev, else clears.
REQ-025 Stall counter reaching STALL_LIMIT in RAMP SHALL transition to ERR; ERR lasts one cycle with err=1, then IDLE; target remains unreached.
REQ-026 Target equal to cnt_q at acceptance SHALL yield RAMP one cycle, DONE one cycle, no nonzero delta issued.
REQ-027 Ramp of N distance takes ceil(N/MAX_STEP) commanding cycles plus one diff=0 cycle before DONE.
REQ-028 External change of cnt_q mid-ramp SHALL be tracked; direction may reverse cycle to cycle.

Reset
REQ-029 Reset asserted SHALL force IDLE, target=0, cnt_q_prev=0, stall counter=0, done=0, err=0, busy=0, tgt_ready=1 asynchronously.
REQ-030 Reset mid-ramp SHALL abandon the target with no done or err pulse.

Configuration
REQ-031 Macro CNT_JUMP_EN defined: JUMP state present; in JUMP cnt_preload=1, cnt_pl_data=target, cnt_delta=0 for one cycle, then RAMP (finishing via DONE).
REQ-032 CNT_JUMP_EN undefined: JUMP state absent, tgt_jump ignored, cnt_preload tied 0, cnt_pl_data tied 0.

Verification
REQ-033 cnt_q=0, target 255 accepted, counter model attached -> 17 cycles delta 15 up, one cycle delta 0, done pulse; cnt_q=255.
REQ-034 cnt_q=200, target 3 -> deltas 15x13 down then 2 down, then done; cnt_q=3, never below 3.
REQ-035 cnt_q=77, target 77 -> busy 2 cycles, done pulse, cnt_delta always 0.
REQ-036 Counter model frozen at 10, target 50 -> err pulse after STALL_LIMIT=8 non-progress cycles, no done, return to IDLE.
REQ-037 CNT_JUMP_EN, cnt_q=5, target 200 with tgt_jump=1 -> one cycle cnt_preload=1 cnt_pl_data=200, then done; without macro same stimulus ramps normally.
REQ-038 Reset asserted during ramp from 0 to 128 -> immediate IDLE, tgt_ready=1, no done/err; second tgt_valid while busy not accepted.
